keypad_hex_capture: RTL and testbench

Receiving end of the 4x4 keypad interface: drives the active-low column scan, samples the active-low rows, debounces and decodes each press to a hex nibble. Assembles nibbles high-first into two 8-bit operands, A then B, and hands them to the divisor core with a valid/ready handshake. Sits between the board keypad pins (`col`/`fil`) and the divider datapath in the top level.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_hex_capture_if.sv | 11 +
 rtl/keypad_debounce.sv | 58 +++++
 rtl/keypad_hex_capture.sv | 134 +++++++++++++
 tb/tb_keypad_hex_capture.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad capture block: assembler state
// encoding, the row/column key map, scan reset value and idle row pattern.
package keypad_pkg;

   typedef enum logic [2:0] {
      A_HI = 3'd0,
      A_LO = 3'd1,
      B_HI = 3'd2,
      B_LO = 3'd3,
      REQ  = 3'd4
   } asm_state_t;

   localparam logic [3:0] COL_RESET  = 4'b1110;
   localparam logic [3:0] ROW_IDLE   = 4'hF;
   localparam logic [3:0] CLEAR_CODE = 4'hE;

   // KEY_MAP[row][col], index 0 = LSB of fil / col
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Index of the lowest zero bit; with several rows low the lowest row wins.
   function automatic logic [1:0] low_index(input logic [3:0] v);
      if (!v[0])      return 2'd0;
      else if (!v[1]) return 2'd1;
      else if (!v[2]) return 2'd2;
      else            return 2'd3;
   endfunction

endpackage

// File: rtl/keypad_hex_capture_if.sv
// Operand handshake between the keypad capture block (master) and the
// divider datapath (slave).
interface keypad_hex_capture_if;
   logic [7:0] A_bin;
   logic [7:0] B_bin;
   logic       op_valid;
   logic       op_ready;

   modport master (output A_bin, output B_bin, output op_valid, input op_ready);
   modport slave  (input A_bin, input B_bin, input op_valid, output op_ready);
endinterface

// File: rtl/keypad_debounce.sv
// Row synchronizer and debouncer. A row pattern becomes the stable pattern
// once it has been seen unchanged for DEBOUNCE_CNT cycles; press pulses for
// one cycle when the stable pattern leaves idle.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fil,
   output logic [3:0] row_sync,
   output logic [3:0] row_stable,
   output logic       press
);

   localparam int CW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
   // The cycle that detects a new pattern already counts as one stable cycle.
   localparam int LOAD_INT = (DEBOUNCE_CNT >= 2) ? DEBOUNCE_CNT - 2 : 0;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_INT);

   logic [3:0]    sync_1;
   logic [3:0]    cand;
   logic [CW-1:0] cnt;

   // Two-flop synchronizer for the asynchronous row pins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1   <= ROW_IDLE;
         row_sync <= ROW_IDLE;
      end else begin
         sync_1   <= fil;
         row_sync <= sync_1;
      end
   end

   // Stable-count down-counter; any pattern change reloads it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand       <= ROW_IDLE;
         cnt        <= '0;
         row_stable <= ROW_IDLE;
         press      <= 1'b0;
      end else begin
         press <= 1'b0;
         if (row_sync != cand) begin
            cand <= row_sync;
            cnt  <= CNT_LOAD;
         end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end else if (cand != row_stable) begin
            row_stable <= cand;
            press      <= (cand != ROW_IDLE) && (row_stable == ROW_IDLE);
         end
      end
   end

endmodule

// File: rtl/keypad_hex_capture.sv
// Keypad receiver: column scan, key decode, and assembly of four nibbles
// (A high, A low, B high, B low) into operands handed to the divider.
// Optional build macro KEYPAD_CLEAR_KEY_EN turns key E into a clear key.
//
// state | meaning
// A_HI  | waiting for high nibble of A
// A_LO  | waiting for low nibble of A
// B_HI  | waiting for high nibble of B
// B_LO  | waiting for low nibble of B; next key publishes A/B
// REQ   | op_valid high, operands held until op_ready
module keypad_hex_capture
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fil,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   keypad_hex_capture_if.master op
);

   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LOAD = SW'((SCAN_DIV > 1) ? SCAN_DIV - 1 : 0);

   logic [3:0]    row_sync;
   logic [3:0]    row_stable;
   logic          press;
   logic          frozen;
   logic [SW-1:0] scan_cnt;

   asm_state_t    state;
   logic [7:0]    sh_a;
   logic [3:0]    sh_b_hi;
   logic [7:0]    a_bin;
   logic [7:0]    b_bin;
   logic          op_valid;

   keypad_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .fil        (fil),
      .row_sync   (row_sync),
      .row_stable (row_stable),
      .press      (press)
   );

   // Column stays put while a row is low or a press has not yet released
   assign frozen = (row_sync != ROW_IDLE) || (row_stable != ROW_IDLE);

   // Column scan: rotate the driven-low column every SCAN_DIV idle cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col      <= COL_RESET;
         scan_cnt <= SCAN_LOAD;
      end else if (frozen) begin
         scan_cnt <= SCAN_LOAD;
      end else if (scan_cnt == '0) begin
         col      <= {col[2:0], col[3]};
         scan_cnt <= SCAN_LOAD;
      end else begin
         scan_cnt <= scan_cnt - SW'(1);
      end
   end

   // Decode the debounced press against the frozen column
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid <= 1'b0;
         key_code  <= 4'h0;
      end else begin
         key_valid <= press;
         if (press) begin
            key_code <= KEY_MAP[low_index(row_stable)][low_index(col)];
         end
      end
   end

   // Operand assembler and divider handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= A_HI;
         sh_a     <= 8'h00;
         sh_b_hi  <= 4'h0;
         a_bin    <= 8'h00;
         b_bin    <= 8'h00;
         op_valid <= 1'b0;
      end else if (state == REQ) begin
         if (op.op_ready) begin
            op_valid <= 1'b0;
            state    <= A_HI;
         end
      end else if (key_valid) begin
`ifdef KEYPAD_CLEAR_KEY_EN
         if (key_code == CLEAR_CODE) begin
            state   <= A_HI;
            sh_a    <= 8'h00;
            sh_b_hi <= 4'h0;
         end else
`endif
         begin
            case (state)
               A_HI: begin
                  sh_a[7:4] <= key_code;
                  state     <= A_LO;
               end
               A_LO: begin
                  sh_a[3:0] <= key_code;
                  state     <= B_HI;
               end
               B_HI: begin
                  sh_b_hi <= key_code;
                  state   <= B_LO;
               end
               B_LO: begin
                  a_bin    <= sh_a;
                  b_bin    <= {sh_b_hi, key_code};
                  op_valid <= 1'b1;
                  state    <= REQ;
               end
               default: state <= A_HI;
            endcase
         end
      end
   end

   assign op.A_bin    = a_bin;
   assign op.B_bin    = b_bin;
   assign op.op_valid = op_valid;

endmodule

// File: tb/tb_keypad_hex_capture.sv
// Bench for keypad_hex_capture: keypad pin model, directed scenarios and a
// randomized press sequence checked against a digit-list operand model.
module tb_keypad_hex_capture;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int GAP          = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] fil;
   logic [3:0] col;
   logic       key_valid;
   logic [3:0] key_code;

   logic       key_down = 1'b0;
   logic [3:0] key_sel  = 4'h0;

   logic [3:0] pad_map [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   int total = 0;
   int bad   = 0;

   // operand model: digit list, pending request, last published operands
   logic [3:0] digits [4];
   int         nd = 0;
   bit         m_req = 1'b0;
   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   bit         p_kv = 1'b0;
   bit         p_hs = 1'b0;
   logic [3:0] p_code = 4'h0;
   int         kv_count = 0;
   logic [3:0] exp_codes [$];

   keypad_hex_capture_if op_bus ();

   keypad_hex_capture #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fil       (fil),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .op        (op_bus)
   );

   always #5 clk = ~clk;

   // keypad: the pressed key pulls its row low while its column is driven low
   always_comb begin
      fil = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (key_down && pad_map[r][c] == key_sel && !col[c]) fil[r] = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold, input bit counted);
      key_sel  = code;
      key_down = 1'b1;
      if (counted) exp_codes.push_back(code);
      repeat (hold) @(posedge clk);
      #1 key_down = 1'b0;
      repeat (GAP) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_col"},      32'(col), 32'h0000_000E);
      chk({tag, "_kv"},       32'(key_valid), 32'h0);
      chk({tag, "_code"},     32'(key_code), 32'h0);
      chk({tag, "_a"},        32'(op_bus.A_bin), 32'h0);
      chk({tag, "_b"},        32'(op_bus.B_bin), 32'h0);
      chk({tag, "_op_valid"}, 32'(op_bus.op_valid), 32'h0);
   endtask

   // cycle monitor: applies last cycle's events to the model, then compares
   always @(negedge clk) begin
      if (!rst) begin
         nd = 0; m_req = 1'b0; m_a = 8'h00; m_b = 8'h00;
         p_kv = 1'b0; p_hs = 1'b0; p_code = 4'h0;
         exp_codes.delete();
      end else begin
         if (p_kv && !m_req) begin
`ifdef KEYPAD_CLEAR_KEY_EN
            if (p_code == 4'hE) nd = 0;
            else
`endif
            begin
               digits[nd] = p_code;
               nd++;
               if (nd == 4) begin
                  m_a   = {digits[0], digits[1]};
                  m_b   = {digits[2], digits[3]};
                  m_req = 1'b1;
                  nd    = 0;
               end
            end
         end
         if (p_hs) m_req = 1'b0;
         chk("op_valid", 32'(op_bus.op_valid), 32'(m_req));
         chk("a_bin", 32'(op_bus.A_bin), 32'(m_a));
         chk("b_bin", 32'(op_bus.B_bin), 32'(m_b));
         if (key_valid) begin
            kv_count++;
            if (exp_codes.size() == 0) chk("kv_extra", 32'(key_valid), 32'h0);
            else chk("key_code", 32'(key_code), 32'(exp_codes.pop_front()));
         end
         p_kv   = key_valid;
         p_code = key_code;
         p_hs   = op_bus.op_valid && op_bus.op_ready;
      end
   end

   initial begin
      int  k0;
      bit  moved;
      logic [3:0] c0;
      logic [3:0] code;

      op_bus.op_ready = 1'b1;
      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst0");
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // 4,5,0,7 with op_ready high
      k0 = kv_count;
      press(4'h4, 20, 1'b1);
      press(4'h5, 20, 1'b1);
      press(4'h0, 20, 1'b1);
      press(4'h7, 20, 1'b1);
      chk("s1_kv_count", 32'(kv_count - k0), 32'd4);
      chk("s1_a", 32'(op_bus.A_bin), 32'h45);
      chk("s1_b", 32'(op_bus.B_bin), 32'h07);
      chk("s1_op_valid", 32'(op_bus.op_valid), 32'h0);

      // short glitch on key 9
      k0 = kv_count;
      press(4'h9, 2, 1'b0);
      chk("glitch_kv", 32'(kv_count - k0), 32'd0);
      c0 = col;
      moved = 1'b0;
      for (int i = 0; i < 20 && !moved; i++) begin
         @(negedge clk);
         if (col != c0) moved = 1'b1;
      end
      chk("scan_resume", 32'(moved), 32'h1);
      @(posedge clk);
      #1;

      // request held with op_ready low; key 8 dropped
      op_bus.op_ready = 1'b0;
      press(4'h1, 20, 1'b1);
      press(4'h2, 20, 1'b1);
      press(4'h3, 20, 1'b1);
      press(4'h4, 20, 1'b1);
      chk("req_valid", 32'(op_bus.op_valid), 32'h1);
      chk("req_a", 32'(op_bus.A_bin), 32'h12);
      chk("req_b", 32'(op_bus.B_bin), 32'h34);
      k0 = kv_count;
      press(4'h8, 20, 1'b1);
      repeat (14) @(posedge clk);
      #1;
      chk("req_kv8", 32'(kv_count - k0), 32'd1);
      chk("req_hold_valid", 32'(op_bus.op_valid), 32'h1);
      chk("req_hold_a", 32'(op_bus.A_bin), 32'h12);
      chk("req_hold_b", 32'(op_bus.B_bin), 32'h34);
      op_bus.op_ready = 1'b1;
      @(negedge clk);
      chk("hs_valid_hi", 32'(op_bus.op_valid), 32'h1);
      @(negedge clk);
      chk("hs_valid_lo", 32'(op_bus.op_valid), 32'h0);
      @(posedge clk);
      #1;

      // long hold repeats nothing
      k0 = kv_count;
      press(4'h3, 200, 1'b1);
      chk("hold_kv", 32'(kv_count - k0), 32'd1);

      // reset after three nibbles, mid-debounce of a fourth
      press(4'h7, 20, 1'b1);
      press(4'h1, 20, 1'b1);
      key_sel  = 4'h5;
      key_down = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("rst1");
      key_down = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      press(4'hF, 20, 1'b1);
      press(4'hF, 20, 1'b1);
      press(4'h0, 20, 1'b1);
      press(4'hF, 20, 1'b1);
      chk("post_rst_a", 32'(op_bus.A_bin), 32'hFF);
      chk("post_rst_b", 32'(op_bus.B_bin), 32'h0F);

      // clear-key sequence
      press(4'h1, 20, 1'b1);
      press(4'h2, 20, 1'b1);
      press(4'hE, 20, 1'b1);
      press(4'h9, 20, 1'b1);
`ifndef KEYPAD_CLEAR_KEY_EN
      chk("digit_e_a", 32'(op_bus.A_bin), 32'h12);
      chk("digit_e_b", 32'(op_bus.B_bin), 32'hE9);
`endif
      press(4'h6, 20, 1'b1);
      press(4'h0, 20, 1'b1);
      press(4'h3, 20, 1'b1);
`ifdef KEYPAD_CLEAR_KEY_EN
      chk("clear_a", 32'(op_bus.A_bin), 32'h96);
      chk("clear_b", 32'(op_bus.B_bin), 32'h03);
`endif

      // randomized presses, glitches and op_ready
      for (int i = 0; i < 28; i++) begin
         op_bus.op_ready = ($urandom_range(0, 3) != 0);
         code = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) press(code, $urandom_range(1, 2), 1'b0);
         else press(code, $urandom_range(20, 35), 1'b1);
      end
      op_bus.op_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("kv_missing", 32'(exp_codes.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
